multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle control unit for the RV32I core. It replaces the single-cycle combinational decoder with an FSM that sequences fetch, decode, execute, memory and writeback over several cycles. The unit shares one memory port for instructions and data, stalls on a memory ready handshake, and covers the full RV32I control set: loads, stores, R/I ALU, branches, JAL, JALR, LUI and AUIPC. It adds illegal-instruction and memory-timeout traps and a retired-instruction counter.

Parameters:
ALU_CTRL_W, 4, width of alu_control (encodes add, sub, and, or, xor, slt, sltu, sll, srl, sra)
MEM_TIMEOUT, 0, maximum stall cycles in any memory wait state before trapping; 0 disables the timeout
INSTRET_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
opcode  in  7  instruction[6:0], from the instruction register
funct3  in  3  instruction[14:12]
funct7  in  7  instruction[31:25]
alu_zero  in  1  ALU result == 0
alu_lt  in  1  signed rs1 < rs2
alu_ltu  in  1  unsigned rs1 < rs2
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  PC register load
ir_write  out  1  IR and old_pc register load
adr_src  out  1  memory address select: 0 = PC, 1 = result
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register file write enable
alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1, 11 = zero
alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
result_src  out  2  00 = ALUOut register, 01 = memory data, 10 = live ALU result
imm_src  out  3  immediate format: 000 = I, 001 = S, 010 = B, 011 = U, 100 = J
alu_control  out  ALU_CTRL_W  ALU operation
trap  out  1  sticky; set while the FSM is in TRAP
trap_cause  out  2  01 = illegal instruction, 10 = memory timeout
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset values: state FETCH, instret 0, trap 0, trap_cause 00, stall counter 0.
- While rst is high, all write, request and enable outputs are 0. The first cycle after reset is a fetch.
- Outputs are a Moore decode of state, with two exceptions: gating by mem_ready, and branch pc_write, which depends on the flag inputs.
- FETCH: mem_read=1, adr_src=0, alu_src_a=PC, alu_src_b=4, add, result_src=10. ir_write and pc_write are asserted only in the cycle mem_ready=1. Then go to DECODE; otherwise hold.
- DECODE: alu_src_a=old_pc, alu_src_b=imm, imm_src=B, add. This precomputes the branch/AUIPC target into ALUOut. Next state by opcode:
  - load or store: MEMADR
  - R-type: EXECR
  - I-ALU: EXECI
  - branch: BRANCH
  - JAL: JAL
  - JALR: JALR
  - LUI: LUI
  - AUIPC: ALUWB (imm_src=U in DECODE for AUIPC)
  - FENCE: FETCH (retires as nop)
  - anything else, including SYSTEM: TRAP with cause 01
- MEMADR: rs1 + imm (I or S format). Go to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: adr_src=1, mem_read=1. Hold until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, mem_write=1. Hold until mem_ready, then FETCH.
- EXECR: rs1 op rs2, then ALUWB.
- EXECI: rs1 op imm, then ALUWB.
- ALU decode for EXECR/EXECI:
  - funct3 000: sub only if R-type and funct7[5]=1; otherwise add.
  - funct3 101: funct7 0x00 gives srl, 0x20 gives sra.
  - Illegal: R-type funct7 outside {0x00, 0x20}; 0x20 with funct3 other than 000 or 101; slli/srli/srai with a bad funct7. These go to TRAP (cause 01) from DECODE instead of EXECR/EXECI.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: rs1 - rs2, result_src=00. pc_write = taken, where taken is:
  - beq: zero
  - bne: !zero
  - blt: lt
  - bge: !lt
  - bltu: ltu
  - bgeu: !ltu
  - funct3 010 or 011 is illegal and is trapped in DECODE.
  Then FETCH.
- JALR: rs1 + imm (I format), then JAL.
- JAL: alu_src_a=old_pc, alu_src_b=4, add, result_src=00, pc_write=1 (target from ALUOut), then ALUWB (writes old_pc + 4 to rd).
- LUI: alu_src_a=zero, alu_src_b=imm (U format), then ALUWB.
- Memory timeout: the stall counter counts cycles in FETCH, MEMREAD or MEMWRITE with mem_ready=0. It clears on any state change. If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT, go to TRAP with cause 10. mem_ready arriving in the same cycle as the limit wins: the access completes and there is no trap.
- TRAP: all enables are 0; the FSM holds until rst.
- instret: increments by 1 on each transition into FETCH from any non-FETCH, non-reset state. It wraps modulo 2^INSTRET_W. A trapped instruction does not retire.

Decomposition:
- Package: state enum; alu_src_a, alu_src_b, result_src and imm_src encodings; ALU_* control codes widened to 4 bits; RV32I opcode constants (adding BRANCH, JAL, JALR, LUI, AUIPC, I_ALU, FENCE, SYSTEM); FUN3 branch codes; trap cause codes.
- Sub-module: alu_decoder. Combinational, taking (opcode, funct3, funct7, op class) and producing (alu_control, illegal). The FSM instantiates it.

Test Plan:
- add x3,x1,x2 with mem_ready=1 each fetch: FETCH, DECODE, EXECR, ALUWB, FETCH. reg_write=1 only in cycle 4 with alu_control=add. instret goes 0 -> 1.
- lw with mem_ready held low 3 cycles in MEMREAD and MEM_TIMEOUT=8: mem_read held for 4 cycles, MEMWB with result_src=01, then FETCH. trap=0. 5 + 3 = 8 cycles total.
- beq with alu_zero=1, then bne with alu_zero=1: pc_write=1 in BRANCH for the first, 0 for the second. Both return to FETCH.
- jalr: JALR, JAL (pc_write=1, alu_src_a=01, alu_src_b=10), ALUWB (reg_write=1).
- opcode 0x73 (SYSTEM), and separately R-type with funct7=0x01: TRAP, trap_cause=01, no writes. Outputs stay idle until rst, then FETCH with instret=0.
- MEM_TIMEOUT=4, mem_ready=0 in FETCH: trap_cause=10 after 4 stalled cycles. Repeat with mem_ready=1 on cycle 4: no trap. Assert rst mid-MEMWRITE: mem_write=0 in the reset cycle and FETCH next.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared states, mux encodings, ALU codes and RV32I opcodes for the multi-cycle control unit
package multicycle_control_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_TRAP
  } state_t;
  typedef enum logic [1:0] {CLS_ADD, CLS_SUB, CLS_FUNCT} op_class_t;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11;
  localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7, ALU_SRL = 4'd8, ALU_SRA = 4'd9;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I_ALU = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;
  localparam logic [2:0] FUN3_BEQ = 3'b000, FUN3_BNE = 3'b001, FUN3_BLT = 3'b100;
  localparam logic [2:0] FUN3_BGE = 3'b101, FUN3_BLTU = 3'b110, FUN3_BGEU = 3'b111;
  localparam logic [1:0] CAUSE_NONE = 2'b00, CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10;
  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
    return f3 == FUN3_BEQ ? z : f3 == FUN3_BNE ? !z : f3 == FUN3_BLT ? lt :
           f3 == FUN3_BGE ? !lt : f3 == FUN3_BLTU ? ltu : f3 == FUN3_BGEU ? !ltu : 1'b0;
  endfunction
endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// multicycle_control_alu_decoder: maps op class and funct fields to an ALU operation and flags illegal encodings
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  op_class_t  i_class,
  output logic [3:0] o_alu_control,
  output logic       o_illegal
);
  logic w_r, w_f7_ok, w_r_bad, w_i_bad;
  logic [3:0] w_fctrl;
  assign w_r = i_opcode == OP_R;
  assign w_f7_ok = i_funct7 == 7'h00 || i_funct7 == 7'h20;
  assign w_r_bad = !w_f7_ok || (i_funct7 == 7'h20 && i_funct3 != 3'b000 && i_funct3 != 3'b101);
  // for I-ALU funct7 is immediate bits except on shifts
  assign w_i_bad = (i_funct3 == 3'b001 && i_funct7 != 7'h00) || (i_funct3 == 3'b101 && !w_f7_ok);
  always_comb begin
    w_fctrl = ALU_AND;
    case (i_funct3)
      3'b000: w_fctrl = (w_r && i_funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b001: w_fctrl = ALU_SLL;
      3'b010: w_fctrl = ALU_SLT;
      3'b011: w_fctrl = ALU_SLTU;
      3'b100: w_fctrl = ALU_XOR;
      3'b101: w_fctrl = i_funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110: w_fctrl = ALU_OR;
      default: w_fctrl = ALU_AND;
    endcase
  end
  assign o_alu_control = i_class == CLS_FUNCT ? w_fctrl : i_class == CLS_SUB ? ALU_SUB : ALU_ADD;
  assign o_illegal = i_class == CLS_FUNCT && (w_r ? w_r_bad : w_i_bad);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: RV32I multi-cycle control FSM with shared memory port, traps and retired-instruction counter
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int          ALU_CTRL_W  = 4,
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int          INSTRET_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  alu_ltu,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ir_write,
  output logic                  adr_src,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [2:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [INSTRET_W-1:0]  instret
);
  state_t r_state, w_next;
  logic [1:0] r_cause;
  logic [31:0] r_stall;
  logic [INSTRET_W-1:0] r_instret;
  logic w_wait, w_timeout, w_illegal, w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write;
  logic [3:0] w_alu_ctrl;
  op_class_t w_class;
  assign w_wait = r_state == S_FETCH || r_state == S_MEMREAD || r_state == S_MEMWRITE;
  // a ready in the limit cycle completes the access instead of trapping
  assign w_timeout = MEM_TIMEOUT != 0 && w_wait && !mem_ready && r_stall >= MEM_TIMEOUT - 1;
  assign w_class = (r_state == S_DECODE || r_state == S_EXECR || r_state == S_EXECI) ? CLS_FUNCT :
                   r_state == S_BRANCH ? CLS_SUB : CLS_ADD;
  multicycle_control_alu_decoder u_alu_dec (
    .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7), .i_class(w_class),
    .o_alu_control(w_alu_ctrl), .o_illegal(w_illegal)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cause <= CAUSE_NONE;
      r_stall <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_stall <= w_next != r_state ? '0 : (w_wait && !mem_ready) ? r_stall + 32'd1 : r_stall;
      if (w_next == S_TRAP && r_state != S_TRAP) r_cause <= r_state == S_DECODE ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      if (w_next == S_FETCH && r_state != S_FETCH) r_instret <= r_instret + INSTRET_W'(1);
    end
  end
  always_comb begin
    w_next = r_state;
    w_pc_write = 1'b0;
    w_ir_write = 1'b0;
    w_mem_read = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    adr_src = 1'b0;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_src = IMM_I;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        alu_src_b = SRCB_FOUR;
        result_src = RES_ALU;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        w_next = w_timeout ? S_TRAP : mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src = opcode == OP_AUIPC ? IMM_U : opcode == OP_JAL ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R: w_next = w_illegal ? S_TRAP : S_EXECR;
          OP_I_ALU: w_next = w_illegal ? S_TRAP : S_EXECI;
          OP_BRANCH: w_next = funct3[2:1] == 2'b01 ? S_TRAP : S_BRANCH;
          OP_JAL: w_next = S_JAL;
          OP_JALR: w_next = S_JALR;
          OP_LUI: w_next = S_LUI;
          OP_AUIPC: w_next = S_ALUWB;
          OP_FENCE: w_next = S_FETCH;
          default: w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_src = opcode == OP_STORE ? IMM_S : IMM_I;
        w_next = opcode == OP_STORE ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        w_mem_read = 1'b1;
        w_next = w_timeout ? S_TRAP : mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        w_reg_write = 1'b1;
        w_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        w_mem_write = 1'b1;
        w_next = w_timeout ? S_TRAP : mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        w_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        imm_src = IMM_B;
        w_pc_write = branch_taken(funct3, alu_zero, alu_lt, alu_ltu);
        w_next = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_next = S_JAL;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        w_pc_write = 1'b1;
        w_next = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        imm_src = IMM_U;
        w_next = S_ALUWB;
      end
      default: w_next = S_TRAP;
    endcase
  end
  assign pc_write = w_pc_write && !rst;
  assign ir_write = w_ir_write && !rst;
  assign mem_read = w_mem_read && !rst;
  assign mem_write = w_mem_write && !rst;
  assign reg_write = w_reg_write && !rst;
  assign alu_control = ALU_CTRL_W'(r_state == S_DECODE ? ALU_ADD : w_alu_ctrl);
  assign trap = r_state == S_TRAP;
  assign trap_cause = r_cause;
  assign instret = r_instret;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed walk through each instruction class, stalls, traps and reset for multicycle_control
module tb_multicycle_control;
  import multicycle_control_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0, mem_ready = 1'b0;
  logic pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, trap;
  logic [1:0] alu_src_a, alu_src_b, result_src, trap_cause;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic [31:0] instret;
  int n_run = 0, n_fail = 0;
  multicycle_control #(.ALU_CTRL_W(4), .MEM_TIMEOUT(4), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .alu_control(alu_control), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1, "watchdog expired");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask
  task automatic set(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
    mem_ready = 1'b1;
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask
  initial begin
    mem_ready = 1'b1;
    opcode = OP_R;
    #1;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_pc_write", pc_write, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_trap", trap, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_instret", instret, 0);
    set(OP_R, 3'b000, 7'h00);
    chk("add_f_mem_read", mem_read, 1);
    chk("add_f_ir_write", ir_write, 1);
    chk("add_f_pc_write", pc_write, 1);
    chk("add_f_srcb", alu_src_b, 2);
    chk("add_f_res", result_src, 2);
    chk("add_f_alu", alu_control, ALU_ADD);
    tick();
    chk("add_d_srca", alu_src_a, 1);
    chk("add_d_srcb", alu_src_b, 1);
    chk("add_d_imm", imm_src, 2);
    chk("add_d_mem_read", mem_read, 0);
    chk("add_d_reg_write", reg_write, 0);
    tick();
    chk("add_e_srca", alu_src_a, 2);
    chk("add_e_srcb", alu_src_b, 0);
    chk("add_e_alu", alu_control, ALU_ADD);
    chk("add_e_reg_write", reg_write, 0);
    tick();
    chk("add_wb_reg_write", reg_write, 1);
    chk("add_wb_res", result_src, 0);
    chk("add_wb_instret", instret, 0);
    tick();
    chk("add_instret", instret, 1);
    chk("add_back_fetch", mem_read, 1);
    set(OP_R, 3'b000, 7'h20);
    tick();
    tick();
    chk("sub_alu", alu_control, ALU_SUB);
    tick();
    tick();
    chk("sub_instret", instret, 2);
    set(OP_I_ALU, 3'b101, 7'h20);
    tick();
    tick();
    chk("srai_alu", alu_control, ALU_SRA);
    chk("srai_srcb", alu_src_b, 1);
    tick();
    chk("srai_wb", reg_write, 1);
    tick();
    chk("srai_instret", instret, 3);
    set(OP_LOAD, 3'b010, 7'h00);
    tick();
    tick();
    chk("lw_adr_srca", alu_src_a, 2);
    chk("lw_adr_srcb", alu_src_b, 1);
    chk("lw_adr_imm", imm_src, 0);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_stall_mem_read", mem_read, 1);
      chk("lw_stall_adr_src", adr_src, 1);
      chk("lw_stall_trap", trap, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_ready_mem_read", mem_read, 1);
    tick();
    chk("lw_wb_res", result_src, 1);
    chk("lw_wb_reg_write", reg_write, 1);
    chk("lw_wb_trap", trap, 0);
    tick();
    chk("lw_instret", instret, 4);
    alu_zero = 1'b1;
    set(OP_BRANCH, FUN3_BEQ, 7'h00);
    tick();
    tick();
    chk("beq_pc_write", pc_write, 1);
    chk("beq_alu", alu_control, ALU_SUB);
    chk("beq_res", result_src, 0);
    tick();
    chk("beq_instret", instret, 5);
    set(OP_BRANCH, FUN3_BNE, 7'h00);
    tick();
    tick();
    chk("bne_pc_write", pc_write, 0);
    tick();
    chk("bne_instret", instret, 6);
    chk("bne_fetch", mem_read, 1);
    alu_zero = 1'b0;
    alu_lt = 1'b1;
    set(OP_BRANCH, FUN3_BLT, 7'h00);
    tick();
    tick();
    chk("blt_pc_write", pc_write, 1);
    tick();
    set(OP_JALR, 3'b000, 7'h00);
    tick();
    tick();
    chk("jalr_srca", alu_src_a, 2);
    chk("jalr_pc_write", pc_write, 0);
    tick();
    chk("jal_pc_write", pc_write, 1);
    chk("jal_srca", alu_src_a, 1);
    chk("jal_srcb", alu_src_b, 2);
    chk("jal_res", result_src, 0);
    tick();
    chk("jalr_wb", reg_write, 1);
    tick();
    chk("jalr_instret", instret, 8);
    set(OP_LUI, 3'b000, 7'h00);
    tick();
    tick();
    chk("lui_srca", alu_src_a, 3);
    chk("lui_imm", imm_src, 3);
    tick();
    chk("lui_wb", reg_write, 1);
    tick();
    set(OP_FENCE, 3'b000, 7'h00);
    tick();
    tick();
    chk("fence_instret", instret, 10);
    set(OP_STORE, 3'b010, 7'h00);
    tick();
    tick();
    chk("sw_adr_imm", imm_src, 1);
    mem_ready = 1'b0;
    tick();
    chk("sw_mem_write", mem_write, 1);
    chk("sw_adr_src", adr_src, 1);
    rst = 1'b1;
    #1;
    chk("sw_rst_mem_write", mem_write, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("sw_rst_fetch", mem_read, 1);
    chk("sw_rst_mem_write_after", mem_write, 0);
    chk("sw_rst_instret", instret, 0);
    set(OP_SYSTEM, 3'b000, 7'h00);
    tick();
    tick();
    chk("sys_trap", trap, 1);
    chk("sys_cause", trap_cause, 1);
    chk("sys_reg_write", reg_write, 0);
    chk("sys_pc_write", pc_write, 0);
    tick();
    tick();
    tick();
    chk("sys_hold_trap", trap, 1);
    chk("sys_hold_mem_read", mem_read, 0);
    chk("sys_hold_ir_write", ir_write, 0);
    do_reset();
    chk("sys_rst_trap", trap, 0);
    chk("sys_rst_cause", trap_cause, 0);
    chk("sys_rst_instret", instret, 0);
    chk("sys_rst_fetch", mem_read, 1);
    set(OP_R, 3'b000, 7'h01);
    tick();
    tick();
    chk("rbad_trap", trap, 1);
    chk("rbad_cause", trap_cause, 1);
    chk("rbad_reg_write", reg_write, 0);
    chk("rbad_instret", instret, 0);
    do_reset();
    opcode = OP_R;
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("to_stall_trap", trap, 0);
      chk("to_stall_mem_read", mem_read, 1);
      tick();
    end
    chk("to_trap", trap, 1);
    chk("to_cause", trap_cause, 2);
    chk("to_mem_read", mem_read, 0);
    do_reset();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("edge_stall_trap", trap, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("edge_ir_write", ir_write, 1);
    tick();
    chk("edge_no_trap", trap, 0);
    chk("edge_decode", alu_src_a, 1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
